// File: rtl/mac_seq_border.sv
// Operand sequencer for the border PE of the bit-serial systolic array.
// Accepts ifm/wght pairs over valid/ready and steps one MAC per 2**IDEPTH cycles.
module mac_seq_border #(
  parameter int IWIDTH = 16,
  parameter int IDEPTH = 4,
  parameter int LWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LWIDTH-1:0]        len,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] in_ifm,
  input  logic signed [IWIDTH-1:0] in_wght,
  output logic [IDEPTH-1:0]        idx,
  output logic                     mac_done,
  output logic                     en_i,
  output logic                     en_w,
  output logic                     clr_i,
  output logic                     clr_w,
  output logic                     en_o,
  output logic                     clr_o,
  output logic signed [IWIDTH-1:0] ifm,
  output logic signed [IWIDTH-1:0] wght
);

  typedef enum logic [1:0] {IDLE, FETCH, RUN, FIN} state_t;

  localparam logic [IDEPTH-1:0] IDX_LAST = '1;
  localparam logic [IDEPTH-1:0] IDX_PRE  = IDX_LAST - 1'b1;
  localparam logic [LWIDTH-1:0] CNT_ONE  = LWIDTH'(1);

  state_t                  state_q, state_d;
  logic [IDEPTH-1:0]       idx_q, idx_d;
  logic [LWIDTH-1:0]       cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic                    busy_q, busy_d, done_q, done_d, in_ready_q, in_ready_d;
  logic                    mac_done_q, mac_done_d, en_i_q, en_i_d, en_w_q, en_w_d;
  logic                    en_o_q, en_o_d, clr_i_q, clr_i_d, clr_w_q, clr_w_d;
  logic                    clr_o_q, clr_o_d;
  logic signed [IWIDTH-1:0] ifm_q, ifm_d, wght_q, wght_d;
  logic                    take;

  // Every output is a register, so the next cycle's control word is built here.
  // A taken handshake overrides the per-state result and opens idx=0 of a MAC.
  always_comb begin
    state_d    = state_q;
    idx_d      = '0;
    cnt_d      = cnt_q;
    first_d    = first_q;
    ifm_d      = ifm_q;
    wght_d     = wght_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    in_ready_d = 1'b0;
    mac_done_d = 1'b0;
    en_i_d     = 1'b0;
    en_w_d     = 1'b0;
    en_o_d     = 1'b0;
    clr_i_d    = 1'b0;
    clr_w_d    = 1'b0;
    clr_o_d    = 1'b0;
    take       = in_valid && in_ready_q && !abort;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      first_d = 1'b0;
      clr_i_d = 1'b1;
      clr_w_d = 1'b1;
      clr_o_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state_d    = FETCH;
              cnt_d      = len;
              first_d    = 1'b1;
              busy_d     = 1'b1;
              in_ready_d = 1'b1;
            end else begin
              state_d = FIN;
              done_d  = 1'b1;
            end
          end
        end
        FETCH: begin
          busy_d     = 1'b1;
          in_ready_d = !take;
        end
        RUN: begin
          busy_d = 1'b1;
          if (idx_q != IDX_LAST) begin
            idx_d  = idx_q + 1'b1;
            en_o_d = 1'b1;
            if (idx_q == IDX_PRE) begin
              mac_done_d = 1'b1;
              in_ready_d = (cnt_q > CNT_ONE);
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_ONE) begin
              state_d = FIN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else if (!take) begin
              state_d    = FETCH;
              in_ready_d = 1'b1;
            end
          end
        end
        FIN: begin
          state_d = IDLE;
        end
      endcase

      if (take) begin
        state_d = RUN;
        idx_d   = '0;
        en_i_d  = 1'b1;
        en_w_d  = 1'b1;
        en_o_d  = 1'b1;
        clr_o_d = first_q;
        first_d = 1'b0;
        ifm_d   = in_ifm;
        wght_d  = in_wght;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      mac_done_q <= 1'b0;
      en_i_q     <= 1'b0;
      en_w_q     <= 1'b0;
      en_o_q     <= 1'b0;
      clr_i_q    <= 1'b0;
      clr_w_q    <= 1'b0;
      clr_o_q    <= 1'b0;
      ifm_q      <= '0;
      wght_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      mac_done_q <= mac_done_d;
      en_i_q     <= en_i_d;
      en_w_q     <= en_w_d;
      en_o_q     <= en_o_d;
      clr_i_q    <= clr_i_d;
      clr_w_q    <= clr_w_d;
      clr_o_q    <= clr_o_d;
      ifm_q      <= ifm_d;
      wght_q     <= wght_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = in_ready_q;
  assign idx      = idx_q;
  assign mac_done = mac_done_q;
  assign en_i     = en_i_q;
  assign en_w     = en_w_q;
  assign en_o     = en_o_q;
  assign clr_i    = clr_i_q;
  assign clr_w    = clr_w_q;
  assign clr_o    = clr_o_q;
  assign ifm      = ifm_q;
  assign wght     = wght_q;

endmodule
